// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with a return-address stack.
// Sequential, jump, call, return and halt flow control. The stack is a
// circular buffer, so a call on a full stack can overwrite the oldest entry
// instead of faulting. HALT is left with go; FAULT is left only by reset.
module pc_sequencer #(
    parameter int unsigned    W         = 16,
    parameter int unsigned    RAS_DEPTH = 8,
    parameter logic [W-1:0]   RESET_PC  = '0,
    parameter bit             OVF_WRAP  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   op,
    input  logic [1:0]                   skip,
    input  logic [W-1:0]                 target,
    input  logic                         go,
    output logic [W-1:0]                 pc,
    output logic [W-1:0]                 instr_addr1,
    output logic [W-1:0]                 instr_addr2,
    output logic                         halted,
    output logic                         fault,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_JMP  = 3'b001,
        OP_CALL = 3'b010,
        OP_RTN  = 3'b011,
        OP_HALT = 3'b100
    } op_e;

    state_e          state_q, state_d;
    logic [W-1:0]    pc_d;
    logic [CW-1:0]   count_d;
    logic            ovf_d;
    logic            push, pop;

    // sp_q points at the next free slot; the top of stack is sp_q-1.
    logic [PW-1:0]   sp_q;
    logic [W-1:0]    ras_mem [RAS_DEPTH];

    // Address after the current instruction and its immediates; both the
    // sequential successor and the return address pushed by CALL.
    logic [W-1:0]    pc_seq;
    logic [W-1:0]    ras_top;

    assign pc_seq      = pc + W'(1) + W'(skip);
    assign ras_top     = ras_mem[sp_q - PW'(1)];

    assign instr_addr1 = pc;
    assign instr_addr2 = pc + W'(1);
    assign halted      = (state_q == ST_HALT);
    assign fault       = (state_q == ST_FAULT);
    assign ras_empty   = (ras_count == '0);
    assign ras_full    = (ras_count == CW'(RAS_DEPTH));

    // Next-state, next-pc and stack control decode; stall freezes everything.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc;
        count_d = ras_count;
        ovf_d   = ras_ovf;
        push    = 1'b0;
        pop     = 1'b0;
        if (!stall) begin
            unique case (state_q)
                ST_RUN: begin
                    case (op)
                        OP_SEQ: pc_d = pc_seq;
                        OP_JMP: pc_d = target;
                        OP_CALL: begin
                            if (ras_full) begin
                                ovf_d = 1'b1;
                                if (OVF_WRAP) begin
                                    // Writing the slot after the newest entry overwrites the oldest.
                                    push = 1'b1;
                                    pc_d = target;
                                end else begin
                                    state_d = ST_FAULT;
                                end
                            end else begin
                                push    = 1'b1;
                                pc_d    = target;
                                count_d = ras_count + CW'(1);
                            end
                        end
                        OP_RTN: begin
                            if (ras_empty) begin
                                state_d = ST_FAULT;
                            end else begin
                                pop     = 1'b1;
                                pc_d    = ras_top;
                                count_d = ras_count - CW'(1);
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: state_d = ST_HALT;
                    endcase
                end
                ST_HALT: begin
                    if (go) begin
                        state_d = ST_RUN;
                        pc_d    = pc + W'(1);
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: state_d = ST_FAULT;
            endcase
        end
    end

    // State, pc, stack pointer and flags; reset overrides stall and op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc        <= RESET_PC;
            sp_q      <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc        <= pc_d;
            ras_count <= count_d;
            ras_ovf   <= ovf_d;
            if (push) begin
                sp_q <= sp_q + PW'(1);
            end else if (pop) begin
                sp_q <= sp_q - PW'(1);
            end
        end
    end

    // Return-address storage written on push.
    // NOTE: the array is deliberately not reset; entries are only read below ras_count, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_mem[sp_q] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (overflow wraps / overflow faults)
// share one directed stimulus stream. A list-based model per instance is
// compared against every output on every falling edge, and literal values
// pin the model at the points worked out by hand.
module tb_pc_sequencer;

    localparam int W = 16;
    localparam int D = 8;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] CALL = 3'b010;
    localparam logic [2:0] RTN  = 3'b011;
    localparam logic [2:0] HLT  = 3'b100;

    logic          clk = 1'b0;
    logic          reset, stall, go;
    logic [2:0]    op;
    logic [1:0]    skip;
    logic [W-1:0]  target;

    logic [W-1:0]  d_pc     [2];
    logic [W-1:0]  d_ia1    [2];
    logic [W-1:0]  d_ia2    [2];
    logic          d_halted [2];
    logic          d_fault  [2];
    logic [3:0]    d_cnt    [2];
    logic          d_empty  [2];
    logic          d_full   [2];
    logic          d_ovf    [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state, index 0 = wrapping instance, 1 = faulting instance.
    int m_pc    [2];
    int m_cnt   [2];
    bit m_halt  [2];
    bit m_fault [2];
    bit m_ovf   [2];
    int m_stk   [2][D];   // m_stk[k][0] is the oldest live entry

    always #5 clk = ~clk;

    pc_sequencer #(.W(W), .RAS_DEPTH(D), .RESET_PC('0), .OVF_WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .op(op), .skip(skip),
        .target(target), .go(go), .pc(d_pc[0]), .instr_addr1(d_ia1[0]),
        .instr_addr2(d_ia2[0]), .halted(d_halted[0]), .fault(d_fault[0]),
        .ras_count(d_cnt[0]), .ras_empty(d_empty[0]), .ras_full(d_full[0]),
        .ras_ovf(d_ovf[0])
    );

    pc_sequencer #(.W(W), .RAS_DEPTH(D), .RESET_PC('0), .OVF_WRAP(1'b0)) dut_fault (
        .clk(clk), .reset(reset), .stall(stall), .op(op), .skip(skip),
        .target(target), .go(go), .pc(d_pc[1]), .instr_addr1(d_ia1[1]),
        .instr_addr2(d_ia2[1]), .halted(d_halted[1]), .fault(d_fault[1]),
        .ras_count(d_cnt[1]), .ras_empty(d_empty[1]), .ras_full(d_full[1]),
        .ras_ovf(d_ovf[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // One clock of architectural behaviour, stack kept as an ordered list.
    task automatic model_step(input int k, input bit wrap);
        int ret;
        if (reset) begin
            m_pc[k] = 0; m_cnt[k] = 0; m_halt[k] = 0; m_fault[k] = 0; m_ovf[k] = 0;
            return;
        end
        if (stall || m_fault[k]) return;
        if (m_halt[k]) begin
            if (go) begin
                m_halt[k] = 0;
                m_pc[k]   = (m_pc[k] + 1) % 65536;
            end
            return;
        end
        ret = (m_pc[k] + 1 + int'(skip)) % 65536;
        case (op)
            SEQ: m_pc[k] = ret;
            JMP: m_pc[k] = int'(target);
            CALL: begin
                if (m_cnt[k] == D) begin
                    m_ovf[k] = 1;
                    if (wrap) begin
                        for (int i = 0; i < D - 1; i++) m_stk[k][i] = m_stk[k][i+1];
                        m_stk[k][D-1] = ret;
                        m_pc[k] = int'(target);
                    end else begin
                        m_fault[k] = 1;
                    end
                end else begin
                    m_stk[k][m_cnt[k]] = ret;
                    m_cnt[k]++;
                    m_pc[k] = int'(target);
                end
            end
            RTN: begin
                if (m_cnt[k] == 0) begin
                    m_fault[k] = 1;
                end else begin
                    m_cnt[k]--;
                    m_pc[k] = m_stk[k][m_cnt[k]];
                end
            end
            default: m_halt[k] = 1;
        endcase
    endtask

    always @(posedge clk) begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model pc[%0d]", k),        d_pc[k],     m_pc[k]);
                check($sformatf("model addr1[%0d]", k),     d_ia1[k],    m_pc[k]);
                check($sformatf("model addr2[%0d]", k),     d_ia2[k],    (m_pc[k] + 1) % 65536);
                check($sformatf("model halted[%0d]", k),    d_halted[k], m_halt[k]);
                check($sformatf("model fault[%0d]", k),     d_fault[k],  m_fault[k]);
                check($sformatf("model ras_count[%0d]", k), d_cnt[k],    m_cnt[k]);
                check($sformatf("model ras_empty[%0d]", k), d_empty[k],  m_cnt[k] == 0);
                check($sformatf("model ras_full[%0d]", k),  d_full[k],   m_cnt[k] == D);
                check($sformatf("model ras_ovf[%0d]", k),   d_ovf[k],    m_ovf[k]);
            end
        end
    end

    // Apply one set of inputs across one rising edge; returns on the next falling edge.
    task automatic cyc(input logic [2:0] o, input logic [1:0] s = 2'd0,
                       input logic [W-1:0] t = '0, input logic g = 1'b0,
                       input logic st = 1'b0, input logic r = 1'b0);
        op = o; skip = s; target = t; go = g; stall = st; reset = r;
        @(negedge clk);
    endtask

    initial begin
        foreach (m_pc[k]) begin
            m_pc[k] = 0; m_cnt[k] = 0; m_halt[k] = 0; m_fault[k] = 0; m_ovf[k] = 0;
        end
        reset = 1'b1; stall = 1'b0; op = SEQ; skip = 2'd0; target = '0; go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;

        // Reset values
        check("reset pc", d_pc[0], 32'h0);
        check("reset empty", d_empty[0], 32'h1);
        check("reset count", d_cnt[0], 32'h0);
        check("reset halted", d_halted[0], 32'h0);

        // Sequential and jump
        cyc(SEQ, 2'd0);            check("seq skip0 pc", d_pc[0], 32'h0001);
        cyc(SEQ, 2'd2);            check("seq skip2 pc", d_pc[0], 32'h0004);
        cyc(JMP, 2'd0, 16'h0100);  check("jmp pc", d_pc[0], 32'h0100);
        check("jmp addr2", d_ia2[0], 32'h0101);

        // Call / return with an immediate
        cyc(JMP, 2'd0, 16'h0010);  check("jmp 0x10 pc", d_pc[0], 32'h0010);
        cyc(CALL, 2'd1, 16'h0200); check("call pc", d_pc[0], 32'h0200);
        check("call count", d_cnt[0], 32'h1);
        cyc(SEQ);                  check("seq in callee pc", d_pc[0], 32'h0201);
        cyc(RTN);                  check("rtn pc", d_pc[0], 32'h0012);
        check("rtn count", d_cnt[0], 32'h0);

        // Return on empty stack faults; fault ignores ops
        cyc(RTN);                  check("rtn empty fault", d_fault[0], 32'h1);
        check("rtn empty pc", d_pc[0], 32'h0012);
        cyc(JMP, 2'd0, 16'h0300);  check("fault ignores jmp", d_pc[0], 32'h0012);
        cyc(CALL, 2'd0, 16'h0400, 1'b0, 1'b1, 1'b1);
        check("reset while stalled fault", d_fault[0], 32'h0);
        check("reset while stalled pc", d_pc[0], 32'h0);
        cyc(CALL, 2'd0, 16'h0400, 1'b0, 1'b1);
        check("stalled call pc", d_pc[0], 32'h0);
        check("stalled call count", d_cnt[0], 32'h0);

        // Fill the stack: call i from pc 0x100*i to 0x100*(i+1)
        for (int i = 0; i < D; i++) cyc(CALL, 2'd0, 16'((i + 1) * 256));
        check("filled full", d_full[0], 32'h1);
        check("filled ovf", d_ovf[0], 32'h0);
        cyc(CALL, 2'd0, 16'h0900);
        check("wrap call pc", d_pc[0], 32'h0900);
        check("wrap call count", d_cnt[0], 32'h8);
        check("wrap call ovf", d_ovf[0], 32'h1);
        check("nowrap call fault", d_fault[1], 32'h1);
        check("nowrap call pc", d_pc[1], 32'h0800);
        check("nowrap call count", d_cnt[1], 32'h8);
        check("nowrap call ovf", d_ovf[1], 32'h1);
        for (int j = 0; j < D; j++) begin
            cyc(RTN);
            check($sformatf("wrap rtn %0d pc", j), d_pc[0], 32'((D - j) * 256 + 1));
        end
        check("wrap drained empty", d_empty[0], 32'h1);
        check("wrap ovf sticky", d_ovf[0], 32'h1);
        check("nowrap stays faulted", d_fault[1], 32'h1);
        cyc(SEQ, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        check("reset clears fault", d_fault[1], 32'h0);
        check("reset clears ovf", d_ovf[0], 32'h0);

        // Pushed address wraps modulo 2^W
        cyc(JMP, 2'd0, 16'hFFFF);
        cyc(CALL, 2'd1, 16'h0050);
        cyc(RTN);                  check("wrapped return addr", d_pc[0], 32'h0001);

        // PC wrap, halt, go
        cyc(JMP, 2'd0, 16'hFFFE);  check("addr2 near top", d_ia2[0], 32'hFFFF);
        cyc(SEQ, 2'd3);            check("seq wrap pc", d_pc[0], 32'h0002);
        cyc(HLT);                  check("halt halted", d_halted[0], 32'h1);
        for (int i = 0; i < 3; i++) cyc(JMP, 2'd3, 16'h1234);
        check("halt hold pc", d_pc[0], 32'h0002);
        check("halt hold halted", d_halted[0], 32'h1);
        cyc(SEQ, 2'd0, '0, 1'b1, 1'b1);
        check("stall beats go", d_halted[0], 32'h1);
        cyc(SEQ, 2'd0, '0, 1'b1);  check("go pc", d_pc[0], 32'h0003);
        check("go halted", d_halted[0], 32'h0);
        cyc(3'b101);               check("reserved op halts", d_halted[0], 32'h1);
        check("reserved op pc", d_pc[0], 32'h0003);
        cyc(SEQ, 2'd0, '0, 1'b1, 1'b0, 1'b1);
        check("reset in halt", d_halted[0], 32'h0);
        check("reset in halt pc", d_pc[0], 32'h0);
        cyc(SEQ);                  check("run after reset", d_pc[0], 32'h0001);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter W, default 16: width of PC, target and all address outputs.
REQ-002 Parameter RAS_DEPTH, default 8: return-address stack entries; power of 2, >=2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Parameter OVF_WRAP, default 1: 1 = CALL on full stack overwrites oldest entry; 0 = CALL on full stack faults.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold all state this cycle.
REQ-008 op  in  3  000 SEQ, 001 JMP, 010 CALL, 011 RTN, 100 HALT; 101-111 reserved.
REQ-009 skip  in  2  extra words consumed by the current instruction (immediates or skipped words), 0-3.
REQ-010 target  in  W  JMP/CALL destination.
REQ-011 go  in  1  leave HALT.
REQ-012 pc  out  W  registered program counter.
REQ-013 instr_addr1  out  W  equals pc, combinational.
REQ-014 instr_addr2  out  W  equals pc+1 mod 2^W, combinational.
REQ-015 halted  out  1  high in HALT state.
REQ-016 fault  out  1  high in FAULT state.
REQ-017 ras_count  out  clog2(RAS_DEPTH)+1  valid stack entries.
REQ-018 ras_empty, ras_full  out  1 each  ras_count==0 and ras_count==RAS_DEPTH.
REQ-019 ras_ovf  out  1  sticky; set on any CALL issued while full.

Function
REQ-020 States: RUN, HALT, FAULT; one-hot or binary encoding at implementer's choice.
REQ-021 RUN, stall=0, SEQ: pc <= pc+1+skip.
REQ-022 RUN, stall=0, JMP: pc <= target.
REQ-023 RUN, stall=0, CALL: push pc+1+skip; pc <= target; ras_count += 1.
REQ-024 RUN, stall=0, RTN with ras_count>0: pc <= top entry; pop; ras_count -= 1.
REQ-025 RTN with ras_count==0: enter FAULT; pc holds; no stack change.
REQ-026 CALL with ras_full, OVF_WRAP=1: overwrite oldest entry (circular buffer); ras_count stays RAS_DEPTH; pc <= target; ras_ovf <= 1.
REQ-027 CALL with ras_full, OVF_WRAP=0: enter FAULT; pc holds; stack unchanged; ras_ovf <= 1.
REQ-028 HALT op, or any reserved op: enter HALT; pc holds.
REQ-029 HALT state: op, skip and target are ignored; go=1 moves to RUN with pc <= pc+1; go=0 holds.
REQ-030 FAULT state: all inputs ignored except reset; pc and stack hold.
REQ-031 stall=1 has priority over op and go in every state: no pc change, no push or pop, no state change.
REQ-032 All pc arithmetic is modulo 2^W; pc+1+skip and the pushed address wrap silently.
REQ-033 Stack pointer arithmetic wraps modulo RAS_DEPTH.
REQ-034 Pushed return addresses are computed from pc before the update in the same cycle.
REQ-035 Outputs change only on clk edges, except instr_addr1/instr_addr2, which follow pc combinationally.

Reset
REQ-036 reset=1 overrides stall, op and go in the same cycle.
REQ-037 On reset: pc=RESET_PC, state RUN, halted=0, fault=0, ras_count=0, ras_empty=1, ras_full=0, ras_ovf=0.
REQ-038 Stack entry contents need not be cleared; they are unobservable once ras_count=0.
REQ-039 Reset in any state, including FAULT and HALT, or while stalled, returns to the REQ-037 values on the next edge.

Verification
REQ-040 Reset, then SEQ skip=0, SEQ skip=2, JMP target=0x0100 -> pc 0x0001, 0x0004, 0x0100; instr_addr2=0x0101.
REQ-041 pc=0x0010, CALL skip=1 target=0x0200, SEQ, RTN -> pc 0x0200, 0x0201, 0x0012; ras_count goes 1, 1, 0.
REQ-042 OVF_WRAP=1, RAS_DEPTH=8: 9 CALLs from distinct pcs, then 8 RTNs -> ras_ovf=1; returns pop newest-first; the first call's address is lost; ras_empty=1 at end.
REQ-043 OVF_WRAP=0: 8 CALLs then a 9th -> fault=1, pc=the 9th target is not taken, ras_count=8; reset clears fault.
REQ-044 RTN on empty stack -> fault=1, pc unchanged; CALL with stall=1 -> no push, pc unchanged.
REQ-045 pc=0xFFFE, SEQ skip=3 -> pc 0x0002; then HALT, go held 0 for 3 cycles -> pc held, halted=1; go=1 -> pc 0x0003, halted=0.
